// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package busca_pkg;

    localparam int unsigned INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/busca_instr_if.sv
// Instruction-memory request/ready bus between the fetch unit and memory.
interface busca_instr_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
    modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/gerador_imm.sv
// RV immediate generator: selects the I/S/B/U/J layout by opcode and sign-extends to XLEN.
module gerador_imm
    import busca_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: imm32 = {{20{instr[31]}}, instr[31:20]};
            OP_STORE:                 imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OP_BRANCH:                imm32 = {{19{instr[31]}}, instr[31], instr[7],
                                               instr[30:25], instr[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         imm32 = {instr[31:12], 12'b0};
            OP_JAL:                   imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                                               instr[20], instr[30:21], 1'b0};
            default:                  imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/busca_instr.sv
// Multicycle fetch front end: PC, memory handshake, instruction latch, field decode,
// valid/ready handoff to control, redirects and a retired-fetch counter.
module busca_instr
    import busca_pkg::*;
#(
    parameter int unsigned    XLEN     = 64,
    parameter int unsigned    ADDR_W   = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    CNT_W    = 32
) (
    input  logic               Clk,
    input  logic               Reset,
    busca_instr_if.master      mem,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    pc,
    output logic [6:0]         opcode,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [2:0]         funct3,
    output logic [XLEN-1:0]    imm,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               fault,
    output logic [CNT_W-1:0]   fetch_count
);

    state_t          state;
    logic            mem_req_q;
    logic            pend_valid;
    logic [XLEN-1:0] pend_pc;
    logic            misaligned_c;

    assign misaligned_c = |redirect_pc[1:0];

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = pc[ADDR_W-1:0];

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    gerador_imm #(.XLEN(XLEN)) u_imm (
        .instr (instr),
        .imm   (imm)
    );

    // mem_req_q is low in the first REQ cycle after reset, so no word is captured
    // until a request has actually been presented.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            instr       <= NOP;
            instr_valid <= 1'b0;
            mem_req_q   <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= '0;
            pend_valid  <= 1'b0;
            pend_pc     <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    mem_req_q <= 1'b1;
                    if (redirect_valid) begin
                        if (misaligned_c) begin
                            fault     <= 1'b1;
                            mem_req_q <= 1'b0;
                            state     <= ST_HALT;
                        end else begin
                            pc <= redirect_pc;
                        end
                    end else if (mem_req_q && mem.mem_ready) begin
                        instr       <= mem.mem_rdata;
                        instr_valid <= 1'b1;
                        mem_req_q   <= 1'b0;
                        state       <= ST_HOLD;
                    end else if (mem_req_q) begin
                        state <= ST_WAIT;
                    end
                end

                // Address is held until memory answers; a redirect only becomes pending.
                ST_WAIT: begin
                    if (redirect_valid && misaligned_c) begin
                        fault      <= 1'b1;
                        mem_req_q  <= 1'b0;
                        pend_valid <= 1'b0;
                        state      <= ST_HALT;
                    end else if (mem.mem_ready) begin
                        pend_valid <= 1'b0;
                        if (redirect_valid) begin
                            pc    <= redirect_pc;
                            state <= ST_REQ;
                        end else if (pend_valid) begin
                            pc    <= pend_pc;
                            state <= ST_REQ;
                        end else begin
                            instr       <= mem.mem_rdata;
                            instr_valid <= 1'b1;
                            mem_req_q   <= 1'b0;
                            state       <= ST_HOLD;
                        end
                    end else if (redirect_valid) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= redirect_pc;
                    end
                end

                // Redirect wins over instr_ready: the held word is dropped uncounted.
                ST_HOLD: begin
                    if (redirect_valid) begin
                        instr_valid <= 1'b0;
                        if (misaligned_c) begin
                            fault <= 1'b1;
                            state <= ST_HALT;
                        end else begin
                            pc        <= redirect_pc;
                            mem_req_q <= 1'b1;
                            state     <= ST_REQ;
                        end
                    end else if (instr_ready) begin
                        pc          <= pc + XLEN'(4);
                        fetch_count <= fetch_count + CNT_W'(1);
                        instr_valid <= 1'b0;
                        mem_req_q   <= 1'b1;
                        state       <= ST_REQ;
                    end
                end

                default: begin
                    mem_req_q   <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= ST_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_busca_instr.sv
// Self-checking bench for busca_instr: directed corner sequences, an immediate
// decode table, and a randomized run against a transaction-level fetch model.
module tb_busca_instr;
    import busca_pkg::*;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 32;
    localparam logic [XLEN-1:0] RESET_PC = '0;

    typedef struct {
        logic [31:0] w;
        logic [63:0] imm;
    } vec_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc;
    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   imm;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              fault;
    logic [CNT_W-1:0]  fetch_count;
    logic              mem_ready_d;
    logic              word_en;
    logic [31:0]       word_val;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] addrs[$];
    vec_t vecs[10];
    logic [XLEN-1:0] exp_pc;
    int unsigned exp_count;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    busca_instr_if #(.ADDR_W(ADDR_W)) bus ();
    assign bus.mem_ready = mem_ready_d;
    assign bus.mem_rdata = word_en ? word_val : mem_word(bus.mem_addr);

    busca_instr #(
        .XLEN(XLEN), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Reset(Reset), .mem(bus),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .pc(pc),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fault(fault), .fetch_count(fetch_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        mem_ready_d    = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        idle();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_ctrl", 64'({bus.mem_req, instr_valid, fault}), 64'(0));
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", 64'(instr), 64'(NOP));
        check("rst_count", 64'(fetch_count), 64'(0));
        Reset = 1'b1;
        tick();
        check("first_req", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, RESET_PC[31:0]}));
    endtask

    task automatic wait_valid(input int max, input string name);
        int k = 0;
        while (!instr_valid && k < max) begin
            tick();
            k++;
        end
        check(name, 64'(instr_valid), 64'(1));
    endtask

    initial begin
        vecs[0] = '{32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{32'h8000_00EF, 64'hFFFF_FFFF_FFF0_0000};
        vecs[2] = '{32'h1234_5037, 64'h0000_0000_1234_5000};
        vecs[3] = '{32'hFFFF_F117, 64'hFFFF_FFFF_FFFF_F000};
        vecs[4] = '{32'hFE20_AE23, 64'hFFFF_FFFF_FFFF_FFFC};
        vecs[5] = '{32'h0000_0463, 64'h0000_0000_0000_0008};
        vecs[6] = '{32'hFE00_0FE3, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[7] = '{32'h0020_81B3, 64'h0000_0000_0000_0000};
        vecs[8] = '{32'h7FF3_3283, 64'h0000_0000_0000_07FF};
        vecs[9] = '{32'h7FFF_F0EF, 64'h0000_0000_000F_FFFE};

        word_en = 1'b0;
        word_val = '0;
        redirect_pc = '0;
        idle();
        do_reset();

        // Zero-wait memory, control always ready.
        mem_ready_d = 1'b1;
        instr_ready = 1'b1;
        if (bus.mem_req) addrs.push_back(bus.mem_addr);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.mem_req) addrs.push_back(bus.mem_addr);
        end
        check("t1_naddr", 64'(addrs.size() >= 3), 64'(1));
        for (int i = 0; i < 3 && i < addrs.size(); i++)
            check("t1_addr", 64'(addrs[i]), 64'(4 * i));
        check("t1_count", 64'(fetch_count), 64'(3));

        // Three wait states at 0x10.
        mem_ready_d = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h10;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_wait", 64'({bus.mem_req, instr_valid, bus.mem_addr}), 64'({2'b10, 32'h10}));
        end
        mem_ready_d = 1'b1;
        tick();
        mem_ready_d = 1'b0;
        check("t2_valid", 64'(instr_valid), 64'(1));
        check("t2_instr", 64'(instr), 64'(mem_word(32'h10)));
        check("t2_pc", pc, 64'h10);

        // Redirects during WAIT at 0x20; the later one wins, the word is dropped.
        redirect_valid = 1'b1;
        redirect_pc = 64'h20;
        tick();
        redirect_valid = 1'b0;
        tick();
        check("t3_wait", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, 32'h20}));
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        tick();
        redirect_pc = 64'h100;
        tick();
        redirect_valid = 1'b0;
        check("t3_stable", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, 32'h20}));
        mem_ready_d = 1'b1;
        tick();
        check("t3_newaddr", 64'({bus.mem_req, instr_valid, bus.mem_addr}), 64'({2'b10, 32'h100}));
        check("t3_dropped", 64'(instr), 64'(mem_word(32'h10)));
        tick();
        mem_ready_d = 1'b0;
        check("t3_instr", 64'({instr_valid, instr}), 64'({1'b1, mem_word(32'h100)}));
        check("t3_pc", pc, 64'h100);
        check("t3_count", 64'(fetch_count), 64'(3));

        // instr_ready and redirect in the same HOLD cycle.
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        tick();
        idle();
        check("t4_redir", 64'({bus.mem_req, instr_valid, bus.mem_addr}), 64'({2'b10, 32'h40}));
        check("t4_count", 64'(fetch_count), 64'(3));
        mem_ready_d = 1'b1;
        tick();
        mem_ready_d = 1'b0;
        check("t4_instr", 64'({instr_valid, instr}), 64'({1'b1, mem_word(32'h40)}));
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t4_count2", 64'(fetch_count), 64'(4));

        // Misaligned redirect halts until reset.
        redirect_valid = 1'b1;
        redirect_pc = 64'h102;
        tick();
        idle();
        check("t5_fault", 64'({fault, bus.mem_req, instr_valid}), 64'(3'b100));
        for (int i = 0; i < 20; i++) begin
            mem_ready_d = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            redirect_valid = 1'($urandom_range(0, 1));
            redirect_pc = 64'({$urandom_range(0, 255), 2'b00});
            tick();
            check("t5_halt", 64'({fault, bus.mem_req, instr_valid}), 64'(3'b100));
        end
        do_reset();

        // Immediate/field decode table.
        word_en = 1'b1;
        mem_ready_d = 1'b1;
        for (int i = 0; i < 10; i++) begin
            word_val = vecs[i].w;
            if (instr_valid) begin
                instr_ready = 1'b1;
                tick();
                instr_ready = 1'b0;
            end
            wait_valid(8, "imm_valid");
            check("imm_val", imm, vecs[i].imm);
            check("imm_fields", 64'({opcode, rd, rs1, rs2, funct3}),
                  64'({vecs[i].w[6:0], vecs[i].w[11:7], vecs[i].w[19:15],
                       vecs[i].w[24:20], vecs[i].w[14:12]}));
        end
        word_en = 1'b0;

        // Randomized traffic against the transaction-level model.
        do_reset();
        exp_pc = RESET_PC;
        exp_count = 0;
        for (int i = 0; i < 3000; i++) begin
            mem_ready_d = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            redirect_valid = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
            else
                redirect_pc = 64'({$urandom_range(0, 1023), 2'b00});
            if (instr_valid) begin
                check("rnd_pc", pc, exp_pc);
                check("rnd_instr", 64'(instr), 64'(mem_word(exp_pc[31:0])));
            end
            if (redirect_valid)
                exp_pc = redirect_pc;
            else if (instr_valid && instr_ready) begin
                exp_pc = exp_pc + 64'd4;
                exp_count++;
            end
            tick();
            check("rnd_count", 64'(fetch_count), 64'(exp_count));
        end
        idle();
        check("rnd_progress", 64'(exp_count > 100), 64'(1));
        check("rnd_fault", 64'(fault), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
